// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
// Watches a multiplexed 4-digit 7-segment bus and recovers the hex value
// shown on each digit. Inputs are synchronised and then polarity-normalised.
// Each digit must hold still for a while before it is sampled. The sampled
// glyph is decoded back to a nibble, and the results are kept as a 4-digit
// register image.
//
// Ports
//   clk_in       in   1   system clock
//   rst          in   1   asynchronous reset, active-low
//   seg          in   7   segment lines, seg[0]=a .. seg[6]=g
//   anode        in   4   digit enables, anode[i] selects digit i
//   err_clr      in   1   clears decode_err and anode_err
//   digits       out  16  recovered value, digits[4i+3:4i] = digit i
//   digit_valid  out  4   bit i = last capture of digit i was a legal hex glyph
//   frame_valid  out  1   one-cycle pulse once all four digits have been captured
//   decode_err   out  1   sticky: a non-blank, non-hex pattern was captured
//   anode_err    out  1   sticky: more than one anode held active too long
module seg_scan_decoder #(
    parameter int SETTLE_CYCLES = 4,
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic [0:6]  seg,
    input  logic [3:0]  anode,
    input  logic        err_clr,
    output logic [15:0] digits,
    output logic [3:0]  digit_valid,
    output logic        frame_valid,
    output logic        decode_err,
    output logic        anode_err
);

    localparam int             CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [0:6]     SEG_OFF  = ACTIVE_LOW ? 7'h7f : 7'h00;
    localparam logic [3:0]     AN_OFF   = ACTIVE_LOW ? 4'hf : 4'h0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CAPTURE
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [0:6]       seg_s1, seg_s2, sg, sg_prev;
    logic [3:0]       an_s1, an_s2, an, an_prev;
    logic [3:0]       seen;
    logic [1:0]       idx;
    logic             an_chg, sg_chg, one_hot, multi_hot;
    logic             do_sample, anode_set;
    logic [4:0]       dec;

    // Maps a lit-segment pattern to {legal, value}. Anything that is not
    // one of the sixteen hex glyphs comes back with legal=0.
    function automatic logic [4:0] decode_glyph(input logic [0:6] p);
        logic [4:0] r;
        case (p)
            7'b1111110: r = 5'h10;
            7'b0110000: r = 5'h11;
            7'b1101101: r = 5'h12;
            7'b1111001: r = 5'h13;
            7'b0110011: r = 5'h14;
            7'b1011011: r = 5'h15;
            7'b1011111: r = 5'h16;
            7'b1110000: r = 5'h17;
            7'b1111111: r = 5'h18;
            7'b1111011: r = 5'h19;
            7'b1110111: r = 5'h1a;
            7'b0011111: r = 5'h1b;
            7'b1001110: r = 5'h1c;
            7'b0111101: r = 5'h1d;
            7'b1001111: r = 5'h1e;
            7'b1000111: r = 5'h1f;
            default:    r = 5'h00;
        endcase
        return r;
    endfunction

    // Two-flop synchroniser for the asynchronous display bus. During reset
    // the stages hold the "nothing lit" level, so the FSM never sees a
    // phantom digit right after reset is released.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            seg_s1 <= SEG_OFF;
            seg_s2 <= SEG_OFF;
            an_s1  <= AN_OFF;
            an_s2  <= AN_OFF;
        end else begin
            seg_s1 <= seg;
            seg_s2 <= seg_s1;
            an_s1  <= anode;
            an_s2  <= an_s1;
        end
    end

    assign an = ACTIVE_LOW ? ~an_s2 : an_s2;
    assign sg = ACTIVE_LOW ? ~seg_s2 : seg_s2;

    // Previous-clock copies of the normalised bus, used to detect any
    // movement of the anode or segment lines.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            an_prev <= 4'h0;
            sg_prev <= 7'h00;
        end else begin
            an_prev <= an;
            sg_prev <= sg;
        end
    end

    assign an_chg    = (an != an_prev);
    assign sg_chg    = (sg != sg_prev);
    assign multi_hot = ((an & (an - 4'd1)) != 4'h0);
    assign one_hot   = (an != 4'h0) && !multi_hot;
    assign dec       = decode_glyph(sg);

    // Picks the digit index of the single active anode. This index is only
    // used when the anode is one-hot.
    always_comb begin
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (an[i]) idx = 2'(i);
        end
    end

    // Scan FSM state register plus the shared settle / fault counter.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic. SETTLE counts clocks of a completely still bus and
    // samples on the last one. CAPTURE sits until the bus moves again. In
    // IDLE the same counter times how long a multi-hot anode lasts. Once it
    // saturates, anode_set stays high for as long as the fault persists. As
    // a result, an err_clr during a live fault cannot clear the flag.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        do_sample = 1'b0;
        anode_set = 1'b0;
        case (state)
            ST_IDLE: begin
                if (one_hot) begin
                    state_nxt = ST_SETTLE;
                    cnt_nxt   = '0;
                end else if (multi_hot && !an_chg) begin
                    if (cnt == CNT_MAX) anode_set = 1'b1;
                    else                cnt_nxt   = cnt + CNT_W'(1);
                end else begin
                    cnt_nxt = '0;
                end
            end
            ST_SETTLE: begin
                if (an_chg || sg_chg) begin
                    cnt_nxt = '0;
                    if (!one_hot) state_nxt = ST_IDLE;
                end else if (cnt == CNT_MAX) begin
                    do_sample = 1'b1;
                    state_nxt = ST_CAPTURE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_CAPTURE: begin
                if (an_chg) begin
                    cnt_nxt   = '0;
                    state_nxt = one_hot ? ST_SETTLE : ST_IDLE;
                end else if (sg_chg) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_SETTLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Digit image update. A blank or illegal pattern invalidates the digit
    // but leaves the last good nibble in place.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            digits      <= 16'h0000;
            digit_valid <= 4'h0;
        end else if (do_sample) begin
            if (dec[4]) begin
                digits[{idx, 2'b00} +: 4] <= dec[3:0];
                digit_valid[idx]          <= 1'b1;
            end else begin
                digit_valid[idx] <= 1'b0;
            end
        end
    end

    // Sticky error flags. In each flag, the set condition is checked ahead
    // of err_clr so that a simultaneous set and clear leaves the flag set.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            decode_err <= 1'b0;
            anode_err  <= 1'b0;
        end else begin
            if (do_sample && !dec[4] && (sg != 7'h00)) decode_err <= 1'b1;
            else if (err_clr)                          decode_err <= 1'b0;
            if (anode_set)    anode_err <= 1'b1;
            else if (err_clr) anode_err <= 1'b0;
        end
    end

    // Frame tracking. When the mask reads all ones, frame_valid fires for
    // one cycle and the mask restarts. If a sample lands in that same clock,
    // it seeds the fresh mask instead of being dropped.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            seen        <= 4'h0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= (seen == 4'hf);
            if (seen == 4'hf) seen <= do_sample ? an : 4'h0;
            else              seen <= seen | (do_sample ? an : 4'h0);
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder
// Directed bench for seg_scan_decoder in its default configuration
// (SETTLE_CYCLES=4, active-low bus). Stimulus is written in the active-high
// view and inverted onto the pins. Each expected frame is queued when its
// scan is issued. A monitor pops the queue on every frame_valid pulse.
module tb_seg_scan_decoder;

    typedef struct packed {
        logic [15:0] digits;
        logic [3:0]  dv;
        logic        derr;
    } frame_t;

    logic        clk;
    logic        rst;
    logic [0:6]  seg_pins;
    logic [3:0]  an_pins;
    logic        err_clr;
    logic [15:0] digits;
    logic [3:0]  digit_valid;
    logic        frame_valid;
    logic        decode_err;
    logic        anode_err;

    int     tests = 0;
    int     fails = 0;
    frame_t exp_q[$];

    seg_scan_decoder #(
        .SETTLE_CYCLES(4),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .clk_in      (clk),
        .rst         (rst),
        .seg         (seg_pins),
        .anode       (an_pins),
        .err_clr     (err_clr),
        .digits      (digits),
        .digit_valid (digit_valid),
        .frame_valid (frame_valid),
        .decode_err  (decode_err),
        .anode_err   (anode_err)
    );

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-written glyph table, in active-high a..g order.
    function automatic logic [0:6] glyph(input int v);
        logic [0:6] g;
        case (v)
            0:  g = 7'b1111110;
            1:  g = 7'b0110000;
            2:  g = 7'b1101101;
            3:  g = 7'b1111001;
            4:  g = 7'b0110011;
            5:  g = 7'b1011011;
            6:  g = 7'b1011111;
            7:  g = 7'b1110000;
            8:  g = 7'b1111111;
            9:  g = 7'b1111011;
            10: g = 7'b1110111;
            11: g = 7'b0011111;
            12: g = 7'b1001110;
            13: g = 7'b0111101;
            14: g = 7'b1001111;
            default: g = 7'b1000111;
        endcase
        return g;
    endfunction

    // Compares one value and reports any difference.
    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drives the bus (active-high view) and lets it sit for 'cycles' clocks.
    // The task is called at a negative edge and returns at a negative edge.
    task automatic applyStimulus(input logic [3:0] an_hi, input logic [0:6] sg_hi,
                                 input int cycles);
        an_pins  = ~an_hi;
        seg_pins = ~sg_hi;
        repeat (cycles) @(negedge clk);
    endtask

    // Shows a full 4-digit value, one digit at a time.
    task automatic scanValue(input logic [15:0] value, input int dwell);
        logic [3:0] nib;
        for (int d = 0; d < 4; d++) begin
            nib = value[d*4 +: 4];
            applyStimulus(4'b0001 << d, glyph(int'(nib)), dwell);
        end
    endtask

    // Scoreboard monitor. Each frame pulse must match the oldest queued
    // expectation.
    always @(negedge clk) begin
        frame_t e;
        if (rst && frame_valid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL frame_unexpected: got pulse with digits %h, expected no pulse", digits);
            end else begin
                e = exp_q.pop_front();
                checkOutput("frame_digits", digits, e.digits);
                checkOutput("frame_digit_valid", {12'h0, digit_valid}, {12'h0, e.dv});
                checkOutput("frame_decode_err", {15'h0, decode_err}, {15'h0, e.derr});
            end
        end
    end

    // Safety net so the run can never hang.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main directed sequence.
    initial begin
        rst      = 1'b0;
        an_pins  = 4'hf;
        seg_pins = 7'h7f;
        err_clr  = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_digits", digits, 16'h0000);
        checkOutput("rst_digit_valid", {12'h0, digit_valid}, 16'h0);
        checkOutput("rst_frame_valid", {15'h0, frame_valid}, 16'h0);
        checkOutput("rst_decode_err", {15'h0, decode_err}, 16'h0);
        checkOutput("rst_anode_err", {15'h0, anode_err}, 16'h0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // Static scan of 0x1234, two full passes, one pulse per pass.
        exp_q.push_back('{digits: 16'h1234, dv: 4'hf, derr: 1'b0});
        exp_q.push_back('{digits: 16'h1234, dv: 4'hf, derr: 1'b0});
        scanValue(16'h1234, 100);
        scanValue(16'h1234, 100);
        checkOutput("scan_digits", digits, 16'h1234);
        checkOutput("scan_digit_valid", {12'h0, digit_valid}, 16'h000f);

        // Blank digit 2 and illegal digit 3. Their old nibbles are kept.
        exp_q.push_back('{digits: 16'h12c9, dv: 4'h3, derr: 1'b1});
        applyStimulus(4'b0001, glyph(9), 100);
        applyStimulus(4'b0010, glyph(12), 100);
        applyStimulus(4'b0100, 7'b0000000, 100);
        applyStimulus(4'b1000, 7'b1010101, 100);
        checkOutput("blank_illegal_digits", digits, 16'h12c9);
        checkOutput("blank_illegal_valid", {12'h0, digit_valid}, 16'h0003);
        checkOutput("decode_err_set", {15'h0, decode_err}, 16'h1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checkOutput("decode_err_clr", {15'h0, decode_err}, 16'h0);

        // Glitch on digit 1. The nibble changes exactly 7 clocks after the
        // last segment change, and the glitch pattern is never captured.
        applyStimulus(4'b0010, glyph(8), 1);
        applyStimulus(4'b0010, glyph(5), 6);
        checkOutput("glitch_before", {12'h0, digits[7:4]}, 16'hc);
        @(negedge clk);
        checkOutput("glitch_latency", {12'h0, digits[7:4]}, 16'h5);
        applyStimulus(4'b0010, glyph(5), 10);
        checkOutput("glitch_digits", digits, 16'h1259);

        // Two anodes at once. The error sets, the digits stay put, and a
        // clear during the live fault is overridden.
        applyStimulus(4'b0011, glyph(1), 10);
        checkOutput("anode_err_set", {15'h0, anode_err}, 16'h1);
        checkOutput("anode_fault_digits", digits, 16'h1259);
        checkOutput("anode_fault_valid", {12'h0, digit_valid}, 16'h0003);
        err_clr = 1'b1;
        applyStimulus(4'b0011, glyph(1), 1);
        err_clr = 1'b0;
        checkOutput("anode_err_set_wins", {15'h0, anode_err}, 16'h1);
        applyStimulus(4'b0000, 7'b0000000, 8);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checkOutput("anode_err_clr", {15'h0, anode_err}, 16'h0);

        // Frame timing. Repeated digit-0 captures must not pulse; the next
        // pulse needs digits 1..3 again.
        exp_q.push_back('{digits: 16'hf0e8, dv: 4'hf, derr: 1'b0});
        scanValue(16'hf0e8, 40);
        exp_q.push_back('{digits: 16'h3213, dv: 4'hf, derr: 1'b0});
        applyStimulus(4'b0001, glyph(3), 30);
        applyStimulus(4'b0001, glyph(7), 30);
        applyStimulus(4'b0001, glyph(3), 30);
        checkOutput("stuck_digit0_no_frame", 16'(exp_q.size()), 16'd1);
        applyStimulus(4'b0010, glyph(1), 30);
        applyStimulus(4'b0100, glyph(2), 30);
        applyStimulus(4'b1000, glyph(3), 30);
        checkOutput("frames_all_seen", 16'(exp_q.size()), 16'd0);

        // Reset in the middle of a settle. It clears everything at once,
        // and nothing is captured once reset is released.
        applyStimulus(4'b0100, glyph(7), 4);
        rst      = 1'b0;
        an_pins  = 4'hf;
        seg_pins = 7'h7f;
        #1;
        checkOutput("midreset_digits", digits, 16'h0000);
        checkOutput("midreset_valid", {12'h0, digit_valid}, 16'h0);
        checkOutput("midreset_frame", {15'h0, frame_valid}, 16'h0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("post_reset_digits", digits, 16'h0000);
        checkOutput("post_reset_valid", {12'h0, digit_valid}, 16'h0);
        checkOutput("post_reset_queue", 16'(exp_q.size()), 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
